// File: rtl/bus_master_seq_pkg.sv
// Shared definitions for the requester-side bus sequencer.
// Holds the bus command codes, the slot length in beats, a predicate
// telling which commands carry a data line, and the latched transaction
// record. Every other file in this slice imports this package.
package bus_master_seq_pkg;

    localparam int BUS_SLOT_BEATS = 8;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_READX = 3'd2;
    localparam logic [2:0] CMD_UPGR  = 3'd3;
    localparam logic [2:0] CMD_FILL  = 3'd4;
    localparam logic [2:0] CMD_FLUSH = 3'd5;
    localparam logic [2:0] CMD_INV   = 3'd6;

    // Only fill and flush move a line on the data bus.
    function automatic logic cmd_has_data(input logic [2:0] cmd);
        return (cmd == CMD_FILL) || (cmd == CMD_FLUSH);
    endfunction

    typedef struct packed {
        logic [2:0]   cmd;
        logic [4:0]   tag;
        logic [25:0]  addr;
        logic [511:0] data;
    } txn_t;

endpackage

// File: rtl/bus_master_seq_if.sv
// Client handshake and main-bus signals of the bus sequencer.
//   client side : cli_valid/cli_ready, cli_cmd/tag/addr/data,
//                 done, done_ok, done_hit, done_retries
//   bus side    : bus_req, bus_grant, bus_cmd_o/tag_o/addr_o/data_o,
//                 bus_nack, bus_hit
// Modport master is the sequencer; modport slave is the client/bus model.
interface bus_master_seq_if #(
    parameter int MAX_RETRY = 15
) ();
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic           cli_valid;
    logic           cli_ready;
    logic [2:0]     cli_cmd;
    logic [4:0]     cli_tag;
    logic [25:0]    cli_addr;
    logic [511:0]   cli_data;
    logic           done;
    logic           done_ok;
    logic           done_hit;
    logic [RW-1:0]  done_retries;
    logic           bus_req;
    logic           bus_grant;
    logic [2:0]     bus_cmd_o;
    logic [4:0]     bus_tag_o;
    logic [25:0]    bus_addr_o;
    logic [63:0]    bus_data_o;
    logic           bus_nack;
    logic           bus_hit;

    modport master (
        input  cli_valid, cli_cmd, cli_tag, cli_addr, cli_data,
        input  bus_grant, bus_nack, bus_hit,
        output cli_ready, done, done_ok, done_hit, done_retries,
        output bus_req, bus_cmd_o, bus_tag_o, bus_addr_o, bus_data_o
    );

    modport slave (
        output cli_valid, cli_cmd, cli_tag, cli_addr, cli_data,
        output bus_grant, bus_nack, bus_hit,
        input  cli_ready, done, done_ok, done_hit, done_retries,
        input  bus_req, bus_cmd_o, bus_tag_o, bus_addr_o, bus_data_o
    );

endinterface

// File: rtl/bus_master_seq_slot_phase.sv
// bus_slot_phase: free-running 3-bit bus slot phase counter.
// Leaves reset on the same edge as the bus slot counter, so phase tracks
// the bus cycle within the 8-beat slot.
//   clk, rst_n : clock, async active-low reset
//   phase      : current beat 0..7
//   is_last    : phase == 7
module bus_slot_phase (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] phase,
    output logic       is_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 3'd0;
        else        phase <= phase + 3'd1;
    end

    assign is_last = (phase == 3'd7);

endmodule

// File: rtl/bus_master_seq.sv
// bus_master_seq: requester-side bus sequencer for one client.
// Accepts a transaction, arbitrates for the bus, drives an 8-beat owned
// slot and retries on nack with linear backoff (N slots after the Nth nack).
//   clk, rst_n : clock, async active-low reset
//   bus        : client handshake + bus signals (master modport)
//
// state    | meaning
// IDLE     | ready for a client transaction
// ARB      | bus_req high, waiting for grant at phase 7
// XFER     | owned slot, driving cmd/tag/addr/data
// BACKOFF  | waiting `retries` full slots before re-arbitrating
module bus_master_seq
    import bus_master_seq_pkg::*;
#(
    parameter int MAX_RETRY = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_master_seq_if.master   bus
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARB     = 2'd1;
    localparam logic [1:0] ST_XFER    = 2'd2;
    localparam logic [1:0] ST_BACKOFF = 2'd3;

    logic [1:0]    state;
    logic [2:0]    phase;
    logic          is_last;
    txn_t          txn;
    logic [RW-1:0] retries;
    logic [RW-1:0] backoff;
    logic          done_r;
    logic          ok_r;
    logic          hit_r;
    logic [RW-1:0] done_retries_r;
    logic          xfer;

    bus_slot_phase u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .phase   (phase),
        .is_last (is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            txn            <= '0;
            retries        <= '0;
            backoff        <= '0;
            done_r         <= 1'b0;
            ok_r           <= 1'b0;
            hit_r          <= 1'b0;
            done_retries_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cli_valid) begin
                        txn     <= '{cmd: bus.cli_cmd, tag: bus.cli_tag,
                                     addr: bus.cli_addr, data: bus.cli_data};
                        retries <= '0;
                        state   <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (is_last && bus.bus_grant) state <= ST_XFER;
                end
                ST_XFER: begin
                    if (is_last) begin
                        if (bus.bus_nack && (retries < RETRY_MAX)) begin
                            retries <= retries + RW'(1);
                            backoff <= retries + RW'(1);
                            state   <= ST_BACKOFF;
                        end else begin
                            // Either accepted, or nacked with retries exhausted.
                            done_r         <= 1'b1;
                            ok_r           <= ~bus.bus_nack;
                            hit_r          <= bus.bus_hit;
                            done_retries_r <= retries;
                            state          <= ST_IDLE;
                        end
                    end
                end
                ST_BACKOFF: begin
                    // backoff is at least 1 on entry; leave when it hits zero.
                    if (is_last) begin
                        backoff <= backoff - RW'(1);
                        if (backoff == RW'(1)) state <= ST_ARB;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign xfer             = (state == ST_XFER);
    assign bus.cli_ready    = (state == ST_IDLE);
    assign bus.bus_req      = (state == ST_ARB);
    assign bus.bus_cmd_o    = xfer ? txn.cmd  : 3'd0;
    assign bus.bus_tag_o    = xfer ? txn.tag  : 5'd0;
    assign bus.bus_addr_o   = xfer ? txn.addr : 26'd0;
    assign bus.bus_data_o   = (xfer && cmd_has_data(txn.cmd)) ?
                              txn.data[{phase, 6'd0} +: 64] : 64'd0;
    assign bus.done         = done_r;
    assign bus.done_ok      = ok_r;
    assign bus.done_hit     = hit_r;
    assign bus.done_retries = done_retries_r;

endmodule

// File: tb/tb_bus_master_seq.sv
module tb_bus_master_seq;
    import bus_master_seq_pkg::*;

    localparam int MAXR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    always #5 clk = ~clk;

    // Bench's own notion of bus cycle: counts edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    bus_master_seq_if #(.MAX_RETRY(MAXR)) bif ();

    bus_master_seq #(.MAX_RETRY(MAXR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic drive_idle();
        bif.cli_valid = 1'b0;
        bif.cli_cmd   = 3'd0;
        bif.cli_tag   = 5'd0;
        bif.cli_addr  = 26'd0;
        bif.cli_data  = '0;
        bif.bus_grant = 1'b0;
        bif.bus_nack  = 1'b0;
        bif.bus_hit   = 1'b0;
    endtask

    // Runs one transaction from a negedge where the DUT should be idle.
    // skip: phase-7 windows withheld per arbitration; nacks: leading nacked
    // slots; abort_ph >= 0 pulls reset at that slot phase of the first slot.
    task automatic run_txn(input logic [2:0] cmd, input logic [4:0] tag,
                           input logic [25:0] addr, input logic [511:0] data,
                           input int skip, input int nacks, input logic hit,
                           input int abort_ph, input string nm);
        int          a;
        int          windows;
        int          exp_ret;
        logic        exp_ok;
        logic        granted;
        logic [63:0] beat;
        logic [97:0] want;
        logic [97:0] got;

        exp_ok  = (nacks <= MAXR);
        exp_ret = (nacks < MAXR) ? nacks : MAXR;

        tests++;
        if (bif.cli_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept_ready got %b want 1", nm, bif.cli_ready);
        end
        bif.cli_valid = 1'b1;
        bif.cli_cmd   = cmd;
        bif.cli_tag   = tag;
        bif.cli_addr  = addr;
        bif.cli_data  = data;
        @(posedge clk); @(negedge clk);
        // Garbage on the client port must be ignored while busy.
        bif.cli_valid = 1'($urandom);
        bif.cli_cmd   = 3'($urandom);
        bif.cli_tag   = 5'($urandom);
        bif.cli_addr  = 26'($urandom);
        bif.cli_data  = {16{$urandom}};

        a = 0;
        forever begin
            windows = 0;
            granted = 1'b0;
            for (int k = 0; k < 8 * (skip + 2) && !granted; k++) begin
                got = {bif.bus_cmd_o, bif.bus_tag_o, bif.bus_addr_o, bif.bus_data_o};
                tests++;
                if (bif.bus_req !== 1'b1 || bif.cli_ready !== 1'b0 ||
                    bif.done !== 1'b0 || got !== 98'd0) begin
                    fails++;
                    $display("FAIL %s arb a%0d req=%b rdy=%b done=%b outs=%h want req=1 rdy=0 done=0 outs=0",
                             nm, a, bif.bus_req, bif.cli_ready, bif.done, got);
                end
                if (cyc % 8 == 7) begin
                    if (windows < skip) begin
                        bif.bus_grant = 1'b0;
                        windows++;
                    end else begin
                        bif.bus_grant = 1'b1;
                        granted = 1'b1;
                    end
                end else begin
                    bif.bus_grant = 1'($urandom);
                end
                @(posedge clk); @(negedge clk);
            end
            bif.bus_grant = 1'b0;

            for (int p = 0; p < BUS_SLOT_BEATS; p++) begin
                beat = cmd_has_data(cmd) ? data[64*p +: 64] : 64'd0;
                want = {cmd, tag, addr, beat};
                got  = {bif.bus_cmd_o, bif.bus_tag_o, bif.bus_addr_o, bif.bus_data_o};
                tests++;
                if (bif.bus_req !== 1'b0 || bif.done !== 1'b0 || got !== want) begin
                    fails++;
                    $display("FAIL %s slot a%0d p%0d req=%b done=%b outs=%h want req=0 done=0 outs=%h",
                             nm, a, p, bif.bus_req, bif.done, got, want);
                end
                if (p == abort_ph) begin
                    #1 rst_n = 1'b0;
                    #1;
                    got = {bif.bus_cmd_o, bif.bus_tag_o, bif.bus_addr_o, bif.bus_data_o};
                    tests++;
                    if (bif.bus_req !== 1'b0 || got !== 98'd0 || bif.done !== 1'b0 ||
                        bif.cli_ready !== 1'b1) begin
                        fails++;
                        $display("FAIL %s abort req=%b outs=%h done=%b rdy=%b want 0/0/0/1",
                                 nm, bif.bus_req, got, bif.done, bif.cli_ready);
                    end
                    drive_idle();
                    @(negedge clk); @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                bif.bus_nack  = (p == 7) ? (a < nacks) : 1'($urandom);
                bif.bus_hit   = (p == 7) ? hit : 1'($urandom);
                if (p == 7) bif.cli_valid = 1'b0;
                @(posedge clk); @(negedge clk);
            end
            bif.bus_nack = 1'b0;
            bif.bus_hit  = 1'b0;

            if (a >= nacks || a == MAXR) begin
                tests++;
                if (bif.done !== 1'b1 || bif.done_ok !== exp_ok || bif.done_hit !== hit ||
                    bif.done_retries !== exp_ret[$bits(bif.done_retries)-1:0] ||
                    bif.cli_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL %s done done=%b ok=%b hit=%b ret=%0d rdy=%b want 1/%b/%b/%0d/1",
                             nm, bif.done, bif.done_ok, bif.done_hit, bif.done_retries,
                             bif.cli_ready, exp_ok, hit, exp_ret);
                end
                return;
            end

            for (int k = 0; k < 8 * (a + 1); k++) begin
                got = {bif.bus_cmd_o, bif.bus_tag_o, bif.bus_addr_o, bif.bus_data_o};
                tests++;
                if (bif.bus_req !== 1'b0 || bif.done !== 1'b0 || bif.cli_ready !== 1'b0 ||
                    got !== 98'd0) begin
                    fails++;
                    $display("FAIL %s backoff a%0d k%0d req=%b done=%b rdy=%b outs=%h want all 0",
                             nm, a, k, bif.bus_req, bif.done, bif.cli_ready, got);
                end
                bif.bus_grant = 1'($urandom);
                @(posedge clk); @(negedge clk);
            end
            bif.bus_grant = 1'b0;
            a++;
        end
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            tests++;
            if (bif.done !== 1'b0 || bif.cli_ready !== 1'b1 || bif.bus_req !== 1'b0) begin
                fails++;
                $display("FAIL %s idle done=%b rdy=%b req=%b want 0/1/0",
                         nm, bif.done, bif.cli_ready, bif.bus_req);
            end
        end
    endtask

    task automatic test_reset();
        logic [97:0] got;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {bif.bus_cmd_o, bif.bus_tag_o, bif.bus_addr_o, bif.bus_data_o};
        tests++;
        if (bif.cli_ready !== 1'b1 || bif.bus_req !== 1'b0 || bif.done !== 1'b0 ||
            bif.done_ok !== 1'b0 || bif.done_hit !== 1'b0 || bif.done_retries !== '0 ||
            got !== 98'd0) begin
            fails++;
            $display("FAIL reset rdy=%b req=%b done=%b ok=%b hit=%b ret=%0d outs=%h want 1 then zeros",
                     bif.cli_ready, bif.bus_req, bif.done, bif.done_ok, bif.done_hit,
                     bif.done_retries, got);
        end
        rst_n = 1'b1;
        idle_cycles(3, "reset_idle");
    endtask

    task automatic test_fill_basic();
        logic [511:0] d;
        for (int b = 0; b < 8; b++) d[64*b +: 64] = 64'(b + 1);
        run_txn(CMD_FILL, 5'd5, 26'h1234, d, 0, 0, 1'b0, -1, "fill_basic");
        idle_cycles(2, "fill_basic");
    endtask

    task automatic test_nack_once();
        run_txn(CMD_FLUSH, 5'($urandom), 26'($urandom), {16{$urandom}}, 0, 1, 1'b0, -1, "nack_once");
        idle_cycles(2, "nack_once");
    endtask

    task automatic test_max_retry();
        run_txn(CMD_FILL, 5'($urandom), 26'($urandom), {16{$urandom}}, 0, 10, 1'b0, -1, "max_retry");
        idle_cycles(2, "max_retry");
    endtask

    task automatic test_grant_withheld();
        run_txn(CMD_FLUSH, 5'($urandom), 26'($urandom), {16{$urandom}}, 3, 0, 1'b0, -1, "grant_wait");
        idle_cycles(2, "grant_wait");
    endtask

    task automatic test_read_hit();
        run_txn(CMD_READ, 5'($urandom), 26'($urandom), {16{$urandom}}, 0, 0, 1'b1, -1, "read_hit");
        idle_cycles(2, "read_hit");
    endtask

    task automatic test_back_to_back();
        logic [2:0] cmds [4];
        cmds[0] = CMD_FILL; cmds[1] = CMD_READX; cmds[2] = CMD_FLUSH; cmds[3] = CMD_INV;
        for (int i = 0; i < 6; i++) begin
            run_txn(cmds[$urandom_range(0, 3)], 5'($urandom), 26'($urandom), {16{$urandom}},
                    $urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom), -1, "b2b");
        end
        idle_cycles(2, "b2b");
    endtask

    task automatic test_reset_abort();
        run_txn(CMD_FILL, 5'd9, 26'h2aa55, {16{$urandom}}, 0, 0, 1'b0, 3, "abort");
        idle_cycles(12, "abort_after");
        run_txn(CMD_FILL, 5'd3, 26'h3ffff, {16{$urandom}}, 0, 0, 1'b1, -1, "post_abort");
        idle_cycles(2, "post_abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        drive_idle();
        test_reset();
        test_fill_basic();
        test_nack_once();
        test_max_retry();
        test_grant_withheld();
        test_read_hit();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
